lampfpu_sqrt_round_pack: RTL and testbench

- Downstream stage of the square-root / inverse-square-root datapath.
- Consumes the normalised sign/exponent/extended-fraction result and its flags, and applies IEEE round-to-nearest-even.
- Handles mantissa-carry renormalisation and exponent overflow to Inf, then packs the final float.
- Buffers up to two packed results in a small FIFO with valid/ready toward the FPU writeback.

---
 rtl/lampfpu_sqrt_round_pack_pkg.sv | 27 ++
 rtl/lampfpu_res_fifo.sv | 40 ++++
 rtl/lampfpu_sqrt_round_pack.sv | 49 ++++
 tb/tb_lampfpu_sqrt_round_pack.sv | 127 ++++++++++++
 4 files changed

// File: rtl/lampfpu_sqrt_round_pack_pkg.sv
// lampfpu_sqrt_round_pack_pkg: float widths, GRS bit positions, Inf pattern and round-to-nearest-even helper
package lampfpu_sqrt_round_pack_pkg;
    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;
    localparam int LSB_IDX = 3;
    localparam int G_IDX = 2;
    localparam int R_IDX = 1;
    localparam int S_IDX = 0;
    localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] INF_E_F =
        {{LAMP_FLOAT_E_DW{1'b1}}, {LAMP_FLOAT_F_DW{1'b0}}};

    // Returns {ovf, inexact, e, f}; a mantissa carry bumps the exponent and may saturate to Inf.
    function automatic logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW+1:0] round_nearest_even(
        input logic [LAMP_FLOAT_E_DW-1:0] e,
        input logic [LAMP_FLOAT_F_DW+4:0] f
    );
        logic up, inexact;
        logic [LAMP_FLOAT_F_DW:0] sum;
        logic [LAMP_FLOAT_E_DW:0] ex;
        up = f[G_IDX] & (f[R_IDX] | f[S_IDX] | f[LSB_IDX]);
        inexact = f[G_IDX] | f[R_IDX] | f[S_IDX];
        sum = {1'b0, f[LAMP_FLOAT_F_DW+2:3]} + {{LAMP_FLOAT_F_DW{1'b0}}, up};
        ex = {1'b0, e} + {{LAMP_FLOAT_E_DW{1'b0}}, sum[LAMP_FLOAT_F_DW]};
        return (ex >= {1'b0, {LAMP_FLOAT_E_DW{1'b1}}}) ? {1'b1, inexact, INF_E_F}
                                                      : {1'b0, inexact, ex[LAMP_FLOAT_E_DW-1:0], sum[LAMP_FLOAT_F_DW-1:0]};
    endfunction
endpackage

// File: rtl/lampfpu_res_fifo.sv
// lampfpu_res_fifo: DEPTH x W circular FIFO with occupancy count
//   push/din write at the tail, pop advances the head, dout is the head entry, full/empty from count
module lampfpu_res_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rd];
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) mem[wr] <= din;
            wr <= wr + AW'(do_push);
            rd <= rd + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/lampfpu_sqrt_round_pack.sv
// lampfpu_sqrt_round_pack: RNE rounding, Inf saturation and packing of sqrt results into a small result FIFO
//   in : valid_i, s_res_i, e_res_i, f_res_i ("01.f G R S"), isToRound_i, isOverflow_i, isUnderflow_i, ready_i
//   out: ready_o, overrun_o (dropped input pulse), valid_o, res_o {s,e,f}, isOverflow_o, isUnderflow_o, isInexact_o
module lampfpu_sqrt_round_pack
    import lampfpu_sqrt_round_pack_pkg::*;
#(
    parameter int E_DW = LAMP_FLOAT_E_DW,
    parameter int F_DW = LAMP_FLOAT_F_DW,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 s_res_i,
    input  logic [E_DW-1:0]      e_res_i,
    input  logic [F_DW+4:0]      f_res_i,
    input  logic                 isToRound_i,
    input  logic                 isOverflow_i,
    input  logic                 isUnderflow_i,
    output logic                 ready_o,
    output logic                 overrun_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [E_DW+F_DW:0]   res_o,
    output logic                 isOverflow_o,
    output logic                 isUnderflow_o,
    output logic                 isInexact_o
);
    localparam int RW = 1 + E_DW + F_DW;
    localparam int W = RW + 3;
    logic [E_DW+F_DW+1:0] rn;
    logic [RW-1:0] res_in;
    logic [W-1:0] din, dout;
    logic full, empty, push, pop;
    assign rn = round_nearest_even(e_res_i, f_res_i);
    // Specials bypass rounding entirely so NaN/Inf payloads stay untouched.
    assign res_in = isToRound_i ? {s_res_i, rn[E_DW+F_DW-1:0]} : {s_res_i, e_res_i, f_res_i[F_DW+2:3]};
    assign din = {res_in, isOverflow_i | (isToRound_i & rn[E_DW+F_DW+1]), isUnderflow_i, isToRound_i & rn[E_DW+F_DW]};
    // A full buffer can still accept when the head leaves in the same cycle.
    assign ready_o = ~full | ready_i;
    assign push = valid_i & ready_o;
    assign pop = ~empty & ready_i;
    assign valid_o = ~empty;
    assign {res_o, isOverflow_o, isUnderflow_o, isInexact_o} = dout;
    always_ff @(posedge clk) overrun_o <= rst ? 1'b0 : valid_i & ~ready_o;
    lampfpu_res_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .dout(dout), .full(full), .empty(empty)
    );
endmodule

// File: tb/tb_lampfpu_sqrt_round_pack.sv
// tb_lampfpu_sqrt_round_pack: directed vectors with a queue scoreboard and an independent output monitor
module tb_lampfpu_sqrt_round_pack;
    logic clk = 0, rst = 1, valid_i = 0, s_res_i = 0, isToRound_i = 0, isOverflow_i = 0, isUnderflow_i = 0;
    logic ready_i = 1;
    logic [7:0] e_res_i = 0;
    logic [11:0] f_res_i = 0;
    logic ready_o, overrun_o, valid_o, isOverflow_o, isUnderflow_o, isInexact_o;
    logic [15:0] res_o;
    logic [18:0] q[$];
    int n_cmp = 0, n_fail = 0, n_out = 0;

    always #5 clk = ~clk;

    lampfpu_sqrt_round_pack dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .s_res_i(s_res_i), .e_res_i(e_res_i), .f_res_i(f_res_i),
        .isToRound_i(isToRound_i), .isOverflow_i(isOverflow_i), .isUnderflow_i(isUnderflow_i),
        .ready_o(ready_o), .overrun_o(overrun_o), .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o),
        .isOverflow_o(isOverflow_o), .isUnderflow_o(isUnderflow_o), .isInexact_o(isInexact_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Monitor: an entry is consumed at the next posedge whenever valid_o & ready_i hold at negedge.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, required no output", {res_o, isOverflow_o, isUnderflow_o, isInexact_o});
            end else begin
                chk($sformatf("result%0d", n_out), {13'b0, res_o, isOverflow_o, isUnderflow_o, isInexact_o}, {13'b0, q.pop_front()});
                n_out++;
            end
        end
    end

    task automatic send(input logic s, input logic [7:0] e, input logic [11:0] f, input logic rnd,
                        input logic ovf, input logic unf, input logic [18:0] exp, input bit track);
        @(posedge clk);
        #1;
        valid_i = 1;
        s_res_i = s;
        e_res_i = e;
        f_res_i = f;
        isToRound_i = rnd;
        isOverflow_i = ovf;
        isUnderflow_i = unf;
        if (track) q.push_back(exp);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_i = 0;
    endtask

    initial begin
        int waited;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid_o", valid_o, 0);
        chk("reset_res_o", res_o, 0);
        chk("reset_flags", {isOverflow_o, isUnderflow_o, isInexact_o}, 0);
        chk("reset_ready_o", ready_o, 1);
        chk("reset_overrun_o", overrun_o, 0);
        rst = 0;
        send(0, 8'h80, 12'h400, 1, 0, 0, {16'h4000, 3'b000}, 1);
        idle();
        chk("latency_valid_o", valid_o, 1);
        idle();
        send(0, 8'h7F, 12'h7FC, 1, 0, 0, {16'h4000, 3'b001}, 1);
        send(0, 8'h7F, 12'h404, 1, 0, 0, {16'h3F80, 3'b001}, 1);
        send(0, 8'h7F, 12'h40C, 1, 0, 0, {16'h3F82, 3'b001}, 1);
        send(0, 8'hFE, 12'h7FE, 1, 0, 0, {16'h7F80, 3'b101}, 1);
        send(0, 8'hFF, 12'h607, 0, 0, 0, {16'h7FC0, 3'b000}, 1);
        send(1, 8'h00, 12'h400, 1, 1, 1, {16'h8000, 3'b110}, 1);
        idle();
        waited = 0;
        while ((q.size() != 0 || valid_o) && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("drain_timeout", (q.size() == 0 && !valid_o), 1);
        ready_i = 0;
        send(0, 8'h80, 12'h400, 1, 0, 0, {16'h4000, 3'b000}, 1);
        send(0, 8'hFE, 12'h7FE, 1, 0, 0, {16'h7F80, 3'b101}, 1);
        send(0, 8'h7F, 12'h7FC, 1, 0, 0, 19'h0, 0);
        chk("full_ready_o", ready_o, 0);
        chk("full_valid_o", valid_o, 1);
        idle();
        chk("overrun_pulse", overrun_o, 1);
        chk("held_head", {res_o, isOverflow_o, isUnderflow_o, isInexact_o}, {16'h4000, 3'b000});
        @(posedge clk);
        #1;
        chk("overrun_single", overrun_o, 0);
        chk("held_head_again", res_o, 16'h4000);
        ready_i = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("after_drain_valid_o", valid_o, 0);
        chk("after_drain_queue", q.size(), 0);
        ready_i = 0;
        send(0, 8'h7F, 12'h40C, 1, 0, 0, 19'h0, 0);
        idle();
        chk("buffered_valid_o", valid_o, 1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("midreset_valid_o", valid_o, 0);
        chk("midreset_res_o", res_o, 0);
        chk("midreset_ready_o", ready_o, 1);
        ready_i = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
